// File: rtl/latch_bank.sv
// Multi-channel storage bank: per-channel transparent latch (open while clk low) or posedge flop,
// with change detection and update counters. Define LATCH_BANK_CNT_SAT_EN for saturating counters.
`timescale 1ns/1ps
module latch_bank #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS-1:0]       en,
  input  logic [CHANNELS-1:0]       mode,
  input  logic [CHANNELS*WIDTH-1:0] d,
  input  logic                      clr_cnt,
  output logic [CHANNELS*WIDTH-1:0] q,
  output logic [CHANNELS-1:0]       changed,
  output logic [CHANNELS*CNT_W-1:0] upd_cnt
);

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [WIDTH-1:0] d_c;
    logic [WIDTH-1:0] lat_q;
    logic [WIDTH-1:0] flp_q;
    logic [WIDTH-1:0] q_cur;
    logic [WIDTH-1:0] prev;
    logic             lat_stamp;
    logic             flp_ack;
    logic             opened;
    logic             diff;
    logic             chg;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;

    assign d_c = d[c*WIDTH +: WIDTH];

    // The latch marks itself "opened" by flipping its stamp away from the flop's ack bit;
    // the next posedge copies the stamp back, so opened only spans the current low phase.
    always_latch begin
      if (rst) begin
        lat_q     <= '0;
        lat_stamp <= 1'b0;
      end else if (!clk && !mode[c] && en[c]) begin
        lat_q     <= d_c;
        lat_stamp <= ~flp_ack;
      end
    end

    assign opened = lat_stamp ^ flp_ack;
    assign q_cur  = opened ? lat_q : flp_q;
    assign diff   = (q_cur != prev);

`ifdef LATCH_BANK_CNT_SAT_EN
    assign cnt_next = (&cnt) ? cnt : cnt + CNT_W'(1);
`else
    assign cnt_next = cnt + CNT_W'(1);
`endif

    // flp_q follows the visible value whenever it is not capturing, so mode switches never jump.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        flp_q   <= '0;
        flp_ack <= 1'b0;
        prev    <= '0;
        chg     <= 1'b0;
        cnt     <= '0;
      end else begin
        flp_ack <= lat_stamp;
        flp_q   <= (mode[c] && en[c]) ? d_c : q_cur;
        prev    <= q_cur;
        if (clr_cnt) begin
          chg <= 1'b0;
          cnt <= '0;
        end else begin
          chg <= diff;
          if (diff) cnt <= cnt_next;
        end
      end
    end

    assign q[c*WIDTH +: WIDTH]       = q_cur;
    assign changed[c]                = chg;
    assign upd_cnt[c*CNT_W +: CNT_W] = cnt;
  end

endmodule

// File: tb/tb_latch_bank.sv
// Directed plus randomized bench for latch_bank: a 4-channel default instance and a 1-channel
// CNT_W=2 instance, both checked against a phase-level behavioural model.
`timescale 1ns/1ps
module tb_latch_bank;
  localparam int W    = 8;
  localparam int CH   = 4;
  localparam int CW   = 8;
  localparam int CW_S = 2;
  localparam int NM   = CH + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [CH-1:0]    en   = '0;
  logic [CH-1:0]    mode = '0;
  logic [CH*W-1:0]  d    = '0;
  logic             clr  = 1'b0;
  logic [CH*W-1:0]  q;
  logic [CH-1:0]    changed;
  logic [CH*CW-1:0] cnt;

  logic             en_s   = 1'b0;
  logic             mode_s = 1'b0;
  logic [W-1:0]     d_s    = '0;
  logic             clr_s  = 1'b0;
  logic [W-1:0]     q_s;
  logic             changed_s;
  logic [CW_S-1:0]  cnt_s;

  int n_cmp  = 0;
  int n_fail = 0;

  latch_bank #(.WIDTH(W), .CHANNELS(CH), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .d(d), .clr_cnt(clr),
    .q(q), .changed(changed), .upd_cnt(cnt)
  );

  latch_bank #(.WIDTH(W), .CHANNELS(1), .CNT_W(CW_S)) dut_s (
    .clk(clk), .rst(rst), .en(en_s), .mode(mode_s), .d(d_s), .clr_cnt(clr_s),
    .q(q_s), .changed(changed_s), .upd_cnt(cnt_s)
  );

  // clock: posedges at 10, 30, ...; low phase is negedge .. negedge+10
  always #10 clk = ~clk;

  // ---------------- behavioural model (channel CH is the small instance) ----------------
  int unsigned m_q[NM];
  int unsigned m_prev[NM];
  int unsigned m_cnt[NM];
  bit          m_chg[NM];

  function automatic int unsigned cnt_max(int c);
    return (c == CH) ? (2 ** CW_S) - 1 : (2 ** CW) - 1;
  endfunction
  function automatic bit in_en(int c);
    return (c == CH) ? en_s : en[c];
  endfunction
  function automatic bit in_mode(int c);
    return (c == CH) ? mode_s : mode[c];
  endfunction
  function automatic int unsigned in_d(int c);
    return (c == CH) ? int'(d_s) : int'(d[c*W +: W]);
  endfunction
  function automatic bit in_clr(int c);
    return (c == CH) ? clr_s : clr;
  endfunction

  function automatic void model_reset();
    for (int c = 0; c < NM; c++) begin
      m_q[c] = 0; m_prev[c] = 0; m_cnt[c] = 0; m_chg[c] = 0;
    end
  endfunction

  // an open latch shows the present data
  function automatic void model_latch();
    for (int c = 0; c < NM; c++)
      if (!in_mode(c) && in_en(c)) m_q[c] = in_d(c);
  endfunction

  function automatic void model_edge();
    for (int c = 0; c < NM; c++) begin
      int unsigned cur;
      cur = m_q[c];
      if (in_clr(c)) begin
        m_chg[c] = 0;
        m_cnt[c] = 0;
      end else if (cur != m_prev[c]) begin
        m_chg[c] = 1;
`ifdef LATCH_BANK_CNT_SAT_EN
        m_cnt[c] = (m_cnt[c] == cnt_max(c)) ? m_cnt[c] : m_cnt[c] + 1;
`else
        m_cnt[c] = (m_cnt[c] + 1) % (cnt_max(c) + 1);
`endif
      end else begin
        m_chg[c] = 0;
      end
      m_prev[c] = cur;
      if (in_mode(c) && in_en(c)) m_q[c] = in_d(c);
    end
  endfunction

  initial model_reset();
  always @(posedge clk) if (!rst) model_edge();
  always @(negedge clk) if (!rst) model_latch();

  // ---------------- driver / checker tasks ----------------
  task automatic settle();
    if (!clk && !rst) model_latch();
  endtask

  task automatic set_rst(input logic v);
    rst = v;
    if (v) model_reset();
    else settle();
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [CH*W-1:0]  eq;
    logic [CH-1:0]    ec;
    logic [CH*CW-1:0] en_cnt;
    for (int c = 0; c < CH; c++) begin
      eq[c*W +: W]      = W'(m_q[c]);
      ec[c]             = m_chg[c];
      en_cnt[c*CW +: CW] = CW'(m_cnt[c]);
    end
    check({tag, ".q"}, 64'(q), 64'(eq));
    check({tag, ".changed"}, 64'(changed), 64'(ec));
    check({tag, ".upd_cnt"}, 64'(cnt), 64'(en_cnt));
    check({tag, ".q_s"}, 64'(q_s), 64'(W'(m_q[CH])));
    check({tag, ".changed_s"}, 64'(changed_s), 64'(m_chg[CH]));
    check({tag, ".upd_cnt_s"}, 64'(cnt_s), 64'(CW_S'(m_cnt[CH])));
  endtask

  // ---------------- stimulus ----------------
  int unsigned base0;
  int unsigned exp_tab[5];

  initial begin
`ifdef LATCH_BANK_CNT_SAT_EN
    exp_tab = '{1, 2, 3, 3, 3};
`else
    exp_tab = '{1, 2, 3, 0, 1};
`endif
    #25;
    check_all("reset");
    check("reset_q", 64'(q), 64'h0);

    // reset dominates an open latch, which reopens as soon as rst falls in the low phase
    @(negedge clk); #1;
    mode = '0; en = 4'b0001; d[7:0] = 8'hA5; settle();
    #1 check("rst_hold_q0", 64'(q[7:0]), 64'h0);
    set_rst(1'b0);
    #1 check("open_q0", 64'(q[7:0]), 64'hA5);
    set_rst(1'b1);
    #1 check("rst_async_q0", 64'(q[7:0]), 64'h0);
    set_rst(1'b0);
    #1 check("rst_release_q0", 64'(q[7:0]), 64'hA5);
    check_all("rst_release");

    // latch hold through clk high
    @(negedge clk); #2;
    en[1] = 1'b1; d[15:8] = 8'h3C; settle();
    @(posedge clk); #2;
    d[15:8] = 8'hFF; settle();
    #2 check("latch_hold_q1", 64'(q[15:8]), 64'h3C);
    check_all("latch_hold");
    @(negedge clk); #2;
    check("latch_fall_q1", 64'(q[15:8]), 64'hFF);
    check_all("latch_fall");

    // flop capture: only the value present at the edge is taken
    mode[2] = 1'b1; en[2] = 1'b1; d[23:16] = 8'h11; settle();
    #2 check("flop_pre_q2", 64'(q[23:16]), 64'h00);
    #2 d[23:16] = 8'h22; settle();
    #1 check_all("flop_mid");
    @(posedge clk); #2;
    check("flop_cap_q2", 64'(q[23:16]), 64'h22);
    check("flop_cap_chg2", 64'(changed[2]), 64'h0);
    check_all("flop_cap");
    @(posedge clk); #2;
    check("flop_rep_chg2", 64'(changed[2]), 64'h1);
    check("flop_rep_cnt2", 64'(cnt[23:16]), 64'h1);

    // independence: ch3 disabled, ch0 toggling
    en[3] = 1'b0; mode[3] = 1'b0; d[31:24] = 8'h77;
    base0 = m_cnt[0];
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #2;
      d[7:0] = (i % 2 == 0) ? 8'h5A : 8'hA5; settle();
      @(posedge clk); #2;
      check_all("indep");
    end
    check("indep_q3", 64'(q[31:24]), 64'h0);
    check("indep_chg3", 64'(changed[3]), 64'h0);
    check("indep_cnt3", 64'(cnt[31:24]), 64'h0);
    check("indep_cnt0", 64'(cnt[7:0]), 64'((base0 + 5) % 256));

    // counter boundary on the CNT_W=2 instance
    mode_s = 1'b1; en_s = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk); #2;
      if (k < 5) d_s = W'(k + 1);
      @(posedge clk); #2;
      if (k >= 1) begin
        check($sformatf("bound_cnt_%0d", k), 64'(cnt_s), 64'(exp_tab[k-1]));
        check($sformatf("bound_chg_%0d", k), 64'(changed_s), 64'h1);
      end
    end
    @(negedge clk); #2 d_s = 8'h06;
    @(posedge clk); #2;
    @(negedge clk); #2 clr_s = 1'b1;
    @(posedge clk); #2;
    check("clr_cnt_s", 64'(cnt_s), 64'h0);
    check("clr_chg_s", 64'(changed_s), 64'h0);
    check("clr_q_s", 64'(q_s), 64'h06);
    @(negedge clk); #2 clr_s = 1'b0;
    @(posedge clk); #2;
    check("post_clr_chg_s", 64'(changed_s), 64'h0);
    check("post_clr_cnt_s", 64'(cnt_s), 64'h0);
    check_all("post_clr");

    // randomized phase-level traffic on both instances
    for (int i = 0; i < 150; i++) begin
      @(negedge clk); #3;
      en     = CH'($urandom);
      mode   = CH'($urandom);
      d      = $urandom;
      clr    = ($urandom_range(0, 11) == 0);
      en_s   = 1'($urandom);
      mode_s = 1'($urandom);
      d_s    = W'($urandom_range(0, 3));
      clr_s  = ($urandom_range(0, 11) == 0);
      settle();
      #2 check_all("rnd_low_a");
      #2;
      en   = CH'($urandom);
      d    = $urandom;
      en_s = 1'($urandom);
      settle();
      #2 check_all("rnd_low_b");
      @(posedge clk); #3;
      mode = CH'($urandom);
      en   = CH'($urandom);
      d    = $urandom;
      d_s  = W'($urandom_range(0, 3));
      settle();
      #2 check_all("rnd_high");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
